// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: valid/ready operation bus for the pipelined barrel shifter.
//   master - issues operations and consumes results (execute stage / testbench)
//   slave  - the shifter itself
//   in_valid/in_ready/in_data/in_shamt/in_op/in_tag : operation request
//   out_valid/out_ready/out_data/out_tag            : result return
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: elastic barrel shifter, one mux layer per registered stage.
// Supports SLL/SRL/SRA/ROL/ROR plus pass-through ops (101..111). Stage k applies
// a move by 2^k when shamt[k] is set; depth and capacity are log2(WIDTH).
//   clock - rising-edge clock
//   reset - asynchronous active-low reset, clears all stages
//   flush - synchronous discard of all in-flight operations, blocks input
//   io    - operation request / result bus (slave side)
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  pipelined_shifter_if.slave io
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic [SHW-1:0]   vld_p;
  logic [SHW-1:0]   move_p;
  logic [WIDTH-1:0] data_p  [SHW];
  logic [TAG_W-1:0] tag_p   [SHW];
  logic [2:0]       op_p    [SHW];
  logic [SHW-1:0]   shamt_p [SHW];
  logic             sign_p  [SHW];
  logic             accept;

  // One mux layer: optional move by amt. SRA fills from the sign latched at
  // accept, not from the (possibly already shifted) intermediate data.
  function automatic logic [WIDTH-1:0] shift_layer(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sgn,
    input logic             en,
    input int               amt
  );
    logic signed [WIDTH:0] ext;
    ext = $signed({sgn, d}) >>> amt;
    shift_layer = d;
    if (en) begin
      unique case (op)
        OP_SLL:  shift_layer = d << amt;
        OP_SRL:  shift_layer = d >> amt;
        OP_SRA:  shift_layer = ext[WIDTH-1:0];
        OP_ROL:  shift_layer = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  shift_layer = (d >> amt) | (d << (WIDTH - amt));
        default: shift_layer = d;
      endcase
    end
  endfunction

  // A stage advances when some stage downstream of it is empty, or the
  // output is being taken; scanning from the tail avoids a self-referencing
  // ready chain.
  always_comb begin
    logic hole;
    move_p = '0;
    hole   = io.out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      move_p[k] = vld_p[k] & hole;
      hole      = hole | ~vld_p[k];
    end
  end

  assign io.in_ready  = ~flush & (~vld_p[0] | move_p[0]);
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = vld_p[SHW-1];
  assign io.out_data  = data_p[SHW-1];
  assign io.out_tag   = tag_p[SHW-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_p[k]  <= '0;
        tag_p[k]   <= '0;
        op_p[k]    <= '0;
        shamt_p[k] <= '0;
        sign_p[k]  <= 1'b0;
      end
    end else begin
      // ---- stage 0: accept and apply the 1-bit layer ----
      if (accept) begin
        data_p[0]  <= shift_layer(io.in_data, io.in_op, io.in_data[WIDTH-1],
                                  io.in_shamt[0], 1);
        tag_p[0]   <= io.in_tag;
        op_p[0]    <= io.in_op;
        shamt_p[0] <= io.in_shamt;
        sign_p[0]  <= io.in_data[WIDTH-1];
      end
      // ---- stages 1..SHW-1: apply the 2^k layer on advance ----
      for (int k = 1; k < SHW; k++) begin
        if (move_p[k-1]) begin
          data_p[k]  <= shift_layer(data_p[k-1], op_p[k-1], sign_p[k-1],
                                    shamt_p[k-1][k], 1 << k);
          tag_p[k]   <= tag_p[k-1];
          op_p[k]    <= op_p[k-1];
          shamt_p[k] <= shamt_p[k-1];
          sign_p[k]  <= sign_p[k-1];
        end
      end
      if (flush) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= accept | (vld_p[0] & ~move_p[0]);
        for (int k = 1; k < SHW; k++) begin
          vld_p[k] <= move_p[k-1] | (vld_p[k] & ~move_p[k]);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed test of pipelined_shifter at WIDTH=32/TAG_W=5
// and WIDTH=8/TAG_W=2. Inputs change 1 time unit after the rising edge and
// outputs are sampled at least 1 time unit after it.
module tb_pipelined_shifter;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) bus32 ();
  pipelined_shifter_if #(.WIDTH(8),  .TAG_W(2)) bus8 ();

  pipelined_shifter #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clock(clk), .reset(rst_n), .flush(flush), .io(bus32)
  );
  pipelined_shifter #(.WIDTH(8), .TAG_W(2)) dut8 (
    .clock(clk), .reset(rst_n), .flush(flush), .io(bus8)
  );

  localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

  // Issue one op on the 32-bit DUT and wait for its result; lat counts edges
  // from the accept edge (inclusive) to the first out_valid.
  task automatic run32(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tg, output logic [31:0] rd, output logic [4:0] rt,
                       output int lat);
    bus32.in_valid = 1'b1; bus32.in_op = op; bus32.in_data = d;
    bus32.in_shamt = sh;   bus32.in_tag = tg; bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus32.out_data; rt = bus32.out_tag;
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] d, input logic [2:0] sh,
                      input logic [1:0] tg, output logic [7:0] rd, output logic [1:0] rt,
                      output int lat);
    bus8.in_valid = 1'b1; bus8.in_op = op; bus8.in_data = d;
    bus8.in_shamt = sh;   bus8.in_tag = tg; bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus8.out_data; rt = bus8.out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    flush = 1'b0; rst_n = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_shamt = '0; bus32.in_op = '0;
    bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_shamt = '0; bus8.in_op = '0;
    bus8.in_tag = '0; bus8.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid32: got %b expected 0", bus32.out_valid); end
    checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL reset out_data32: got %h expected 0", bus32.out_data); end
    checks++; if (bus32.out_tag !== 5'h0) begin errors++; $display("FAIL reset out_tag32: got %h expected 0", bus32.out_tag); end
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready32: got %b expected 1", bus32.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid8: got %b expected 0", bus8.out_valid); end
    checks++; if (bus8.out_data !== 8'h0) begin errors++; $display("FAIL reset out_data8: got %h expected 0", bus8.out_data); end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_shifts();
    localparam logic [2:0]  OP [5] = '{SRA, SRL, SLL, SRA, SRA};
    localparam logic [31:0] D  [5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                                       32'h7000_0000, 32'hF000_0000};
    localparam logic [4:0]  SH [5] = '{5'd31, 5'd31, 5'd31, 5'd4, 5'd4};
    localparam logic [4:0]  TG [5] = '{5'd3, 5'd17, 5'd30, 5'd12, 5'd1};
    localparam logic [31:0] EX [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000,
                                       32'h0700_0000, 32'hFF00_0000};
    logic [31:0] rd; logic [4:0] rt; int lat;
    for (int i = 0; i < 5; i++) begin
      run32(OP[i], D[i], SH[i], TG[i], rd, rt, lat);
      checks++; if (rd !== EX[i]) begin errors++; $display("FAIL shift%0d data: got %h expected %h", i, rd, EX[i]); end
      checks++; if (rt !== TG[i]) begin errors++; $display("FAIL shift%0d tag: got %0d expected %0d", i, rt, TG[i]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL shift%0d latency: got %0d expected 5", i, lat); end
    end
  endtask

  task automatic test_rotates();
    localparam logic [2:0]  OP [4] = '{ROL, ROR, ROR, 3'b111};
    localparam logic [31:0] D  [4] = '{32'h8000_0001, 32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF};
    localparam logic [4:0]  SH [4] = '{5'd4, 5'd1, 5'd0, 5'd7};
    localparam logic [4:0]  TG [4] = '{5'd5, 5'd9, 5'd21, 5'd31};
    localparam logic [31:0] EX [4] = '{32'h0000_0018, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] rd; logic [4:0] rt; int lat;
    for (int i = 0; i < 4; i++) begin
      run32(OP[i], D[i], SH[i], TG[i], rd, rt, lat);
      checks++; if (rd !== EX[i]) begin errors++; $display("FAIL rot%0d data: got %h expected %h", i, rd, EX[i]); end
      checks++; if (rt !== TG[i]) begin errors++; $display("FAIL rot%0d tag: got %0d expected %0d", i, rt, TG[i]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL rot%0d latency: got %0d expected 5", i, lat); end
    end
  endtask

  // 8 ops SLL (i+1) by i with tag i; out_ready low 4 cycles once the first
  // result shows up.
  task automatic test_backpressure();
    int issued = 0, popped = 0, cyc = 0, stall_left = 0;
    int first_pop = -1, last_pop = -1, first_block = -1, held = -1;
    bit stall_started = 1'b0;
    bit acc, pop;
    logic [31:0] exp_d;
    bus32.out_ready = 1'b1;
    while (popped < 8 && cyc < 60) begin
      bus32.in_valid = (issued < 8);
      bus32.in_op    = SLL;
      bus32.in_data  = 32'(issued + 1);
      bus32.in_shamt = 5'(issued);
      bus32.in_tag   = 5'(issued);
      if (bus32.out_valid && !stall_started) begin
        stall_started = 1'b1;
        stall_left    = 4;
      end
      bus32.out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL bp stall valid c%0d: got %b expected 1", cyc, bus32.out_valid); end
        checks++; if (bus32.out_data !== 32'h1) begin errors++; $display("FAIL bp stall data c%0d: got %h expected 00000001", cyc, bus32.out_data); end
        checks++; if (bus32.out_tag !== 5'd0) begin errors++; $display("FAIL bp stall tag c%0d: got %0d expected 0", cyc, bus32.out_tag); end
      end
      if (bus32.in_valid && !bus32.in_ready && first_block < 0) begin
        first_block = cyc;
        held = issued - popped;
      end
      acc = bus32.in_valid && bus32.in_ready;
      pop = bus32.out_valid && bus32.out_ready;
      if (pop) begin
        exp_d = 32'(popped + 1) << popped;
        checks++; if (bus32.out_tag !== 5'(popped)) begin errors++; $display("FAIL bp order: got tag %0d expected %0d", bus32.out_tag, popped); end
        checks++; if (bus32.out_data !== exp_d) begin errors++; $display("FAIL bp data%0d: got %h expected %h", popped, bus32.out_data, exp_d); end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      @(posedge clk); #1;
      if (acc) issued++;
      if (pop) popped++;
      if (stall_left > 0) stall_left--;
      cyc++;
    end
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    checks++; if (popped != 8) begin errors++; $display("FAIL bp count: got %0d results expected 8", popped); end
    checks++; if (held != 5) begin errors++; $display("FAIL bp in_ready drop: held %0d when blocked expected 5", held); end
    checks++; if (last_pop - first_pop != 7) begin errors++; $display("FAIL bp throughput: span %0d cycles expected 7", last_pop - first_pop); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; logic [4:0] rt; int lat;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus32.in_valid = 1'b1; bus32.in_op = SRL; bus32.in_data = 32'hF0;
      bus32.in_shamt = 5'd4; bus32.in_tag = 5'(10 + i);
      @(posedge clk); #1;
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush early valid %0d: got %b expected 0", i, bus32.out_valid); end
    end
    bus32.in_tag = 5'd13;
    flush = 1'b1;
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready: got %b expected 0", bus32.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; bus32.in_valid = 1'b0;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL flush after valid: got %b expected 0", bus32.out_valid); end
    run32(ROL, 32'h0000_00F1, 5'd8, 5'd20, rd, rt, lat);
    checks++; if (rd !== 32'h0000_F100) begin errors++; $display("FAIL flush next data: got %h expected 0000f100", rd); end
    checks++; if (rt !== 5'd20) begin errors++; $display("FAIL flush next tag: got %0d expected 20", rt); end
    checks++; if (lat != 5) begin errors++; $display("FAIL flush next latency: got %0d expected 5", lat); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic [4:0] rt; int lat; int w = 0; int stale = 0;
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_op = SLL; bus32.in_data = 32'h1; bus32.in_shamt = 5'd3; bus32.in_tag = 5'd1;
    @(posedge clk); #1;
    bus32.in_shamt = 5'd4; bus32.in_tag = 5'd2;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    while (!bus32.out_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL rst setup: out_valid %b expected 1", bus32.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rst async valid: got %b expected 0", bus32.out_valid); end
    checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL rst async data: got %h expected 0", bus32.out_data); end
    checks++; if (bus32.out_tag !== 5'h0) begin errors++; $display("FAIL rst async tag: got %0d expected 0", bus32.out_tag); end
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rst async in_ready: got %b expected 1", bus32.in_ready); end
    #2 rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst stale results: got %0d expected 0", stale); end
    run32(SRA, 32'h8000_0010, 5'd4, 5'd7, rd, rt, lat);
    checks++; if (rd !== 32'hF800_0001) begin errors++; $display("FAIL rst next data: got %h expected f8000001", rd); end
    checks++; if (rt !== 5'd7) begin errors++; $display("FAIL rst next tag: got %0d expected 7", rt); end
    checks++; if (lat != 5) begin errors++; $display("FAIL rst next latency: got %0d expected 5", lat); end
  endtask

  task automatic test_width8();
    localparam logic [2:0] OP [3] = '{SLL, SRA, ROL};
    localparam logic [7:0] D  [3] = '{8'h81, 8'h90, 8'h81};
    localparam logic [2:0] SH [3] = '{3'd7, 3'd3, 3'd1};
    localparam logic [7:0] EX [3] = '{8'h80, 8'hF2, 8'h03};
    logic [7:0] rd; logic [1:0] rt; int lat;
    for (int i = 0; i < 3; i++) begin
      run8(OP[i], D[i], SH[i], 2'(i + 1), rd, rt, lat);
      checks++; if (rd !== EX[i]) begin errors++; $display("FAIL w8_%0d data: got %h expected %h", i, rd, EX[i]); end
      checks++; if (rt !== 2'(i + 1)) begin errors++; $display("FAIL w8_%0d tag: got %0d expected %0d", i, rt, i + 1); end
      checks++; if (lat != 3) begin errors++; $display("FAIL w8_%0d latency: got %0d expected 3", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_rotates();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter for the execute path. Accepts one operand, shift amount, operation code and tag per cycle on a valid/ready handshake. Performs logical left, logical right, arithmetic right, rotate left or rotate right over `log2(WIDTH)` registered mux layers, one layer per stage. Results come out in order with full backpressure support, so the ALU can stall the shifter without losing operations.

## Interface
- `WIDTH`, 32: operand width; power of two, 4 ≤ WIDTH ≤ 64.
- `TAG_W`, 5: width of the pass-through tag (e.g. destination register).
- `SHW` (localparam) = log2(WIDTH): shift-amount width and pipeline depth.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all in-flight operations.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  shifter can accept this cycle.
- `in_data`  in  WIDTH  operand.
- `in_shamt`  in  SHW  shift amount, 0..WIDTH-1.
- `in_op`  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 pass-through (result = operand).
- `in_tag`  in  TAG_W  carried unchanged to output.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result this cycle.
- `out_data`  out  WIDTH  result.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Stage k (0..SHW-1) is a register slot holding: valid, data, op, shamt, sign, tag.
- Stage 0 loads the input. Stage k applies a move by 2^k when `shamt[k]` = 1, otherwise passes data through.
- Vacated bits by op:
  - SLL, SRL: 0.
  - SRA: the sign bit, i.e. `in_data[WIDTH-1]` latched at accept. The sign is not re-derived from intermediate data.
  - ROL, ROR: wrapped bits.
- Pass-through ops ignore shamt.
- Shamt 0 returns the operand unchanged for every op.
- Output is taken directly from the stage SHW-1 register. `out_valid` = stage SHW-1 valid.
- Elastic advance: stage k moves forward when stage k+1 is empty or itself moving. Stage SHW-1 moves when `out_ready`.
- `in_ready` = !flush && (stage 0 empty || stage 0 moving).
- Accept happens when `in_valid && in_ready`.
- A stage that neither loads nor moves holds all fields stable. In particular, `out_data`/`out_tag` stay stable while `out_valid && !out_ready`.
- A stage whose content moves forward with no new load clears its valid bit.
- Capacity is SHW operations. Ordering is strictly FIFO; no drop, no duplication.

## Timing
- Reset (`reset` low): all valid bits 0 and all data/tag registers 0, immediately and without clock. Outputs are `out_valid` 0, `out_data` 0, `out_tag` 0, `in_ready` 1 (flush permitting).
- Reset asserted mid-operation discards every in-flight operation. No partial result appears after release.
- Latency: an operation accepted at edge n gives `out_valid` high after edge n+SHW-1, i.e. SHW cycles after in_valid is sampled (5 for WIDTH=32), when there is no backpressure.
- Throughput: 1 operation per cycle with `out_ready` held high.
- `flush` high at an edge clears all valid bits at that edge. No input is accepted in that cycle (`in_ready` low). If `out_valid && out_ready && flush`, the result is considered consumed. `out_valid` is 0 the cycle after.
- A simultaneous output pop and input accept in a full pipe is legal; every stage advances.
- `out_ready` is not required to be registered. There is no combinational path from `in_valid` to `out_valid`.

## Test plan
- WIDTH=32, no backpressure:
  - SRA 0x8000_0000 by 31 → 0xFFFF_FFFF.
  - SRL 0x8000_0000 by 31 → 0x0000_0001.
  - SLL 0x0000_0001 by 31 → 0x8000_0000.
  - Each has `out_valid` exactly 5 cycles after accept, with the tag preserved.
- Rotates:
  - ROL 0x8000_0001 by 4 → 0x0000_0018.
  - ROR 0x0000_0001 by 1 → 0x8000_0000.
  - ROR 0x1234_5678 by 0 → 0x1234_5678.
  - op 111 on 0xDEAD_BEEF by 7 → 0xDEAD_BEEF.
- Backpressure: 8 back-to-back ops (tags 0..7), `out_ready` low for 4 cycles once the first result is valid.
  - `in_ready` drops after 5 operations are held.
  - All 8 results exit in tag order.
  - `out_data` is stable during the stall.
  - Throughput returns to 1/cycle after `out_ready` rises.
- Flush with 3 ops in flight plus `in_valid` the same cycle: none of the 4 appear. `in_ready` is low that cycle. An op issued the next cycle returns correctly after 5 cycles.
- Reset: assert `reset` low asynchronously between edges with 2 ops in flight. `out_valid`/`out_data` go to 0 immediately. After release, no stale result appears and the next op has normal latency.
- WIDTH=8, TAG_W=2 instance:
  - SLL 0x81 by 7 → 0x80.
  - SRA 0x90 by 3 → 0xF2.
  - ROL 0x81 by 1 → 0x03.
  - Latency is 3 cycles.
